// File: rtl/main_function_multibuf.sv
// N-bank producer/consumer channel: the producer fills and commits whole banks,
// and the consumer reads committed banks in order and then releases them.
module main_function_multibuf #(
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 3,
    parameter int BufferCount  = 3,
    parameter int IndexWidth   = 2
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    i_ce,
    input  logic                    i_write,
    output logic                    i_full_n,
    input  logic                    i_ce0,
    input  logic                    i_we0,
    input  logic [AddressWidth-1:0] i_address0,
    input  logic [DataWidth-1:0]    i_d0,
    output logic [DataWidth-1:0]    i_q0,

    input  logic                    t_ce,
    input  logic                    t_read,
    output logic                    t_empty_n,
    input  logic                    t_ce0,
    input  logic                    t_we0,
    input  logic [AddressWidth-1:0] t_address0,
    input  logic [DataWidth-1:0]    t_d0,
    output logic [DataWidth-1:0]    t_q0,

    output logic [IndexWidth:0]     count
);

    localparam int BankDepth = 2 ** AddressWidth;
    localparam int Depth     = BufferCount * BankDepth;

    localparam logic [IndexWidth-1:0] LastIdx    = IndexWidth'(BufferCount - 1);
    localparam logic [IndexWidth:0]   AlmostFull = (IndexWidth + 1)'(BufferCount - 1);
    localparam logic [IndexWidth:0]   OneBank    = (IndexWidth + 1)'(1);

    // Only pointer values 0..BufferCount-1 are ever used, so the core holds exactly
    // BufferCount banks even when that count is not a power of two.
    logic [DataWidth-1:0] mem [Depth];

    logic [IndexWidth-1:0] iptr_reg;
    logic [IndexWidth-1:0] tptr_reg;
    logic [IndexWidth-1:0] iptr_next;
    logic [IndexWidth-1:0] tptr_next;
    logic [IndexWidth:0]   count_reg;
    logic                  full_n_reg;
    logic                  empty_n_reg;
    logic [DataWidth-1:0]  i_q_reg;
    logic [DataWidth-1:0]  t_q_reg;

    logic push;
    logic pop;
    logic i_rd;
    logic i_wr;
    logic t_rd;
    logic t_wr;

    logic [IndexWidth+AddressWidth-1:0] i_addr_phys;
    logic [IndexWidth+AddressWidth-1:0] t_addr_phys;

    assign push = i_ce & i_write & full_n_reg;
    assign pop  = t_ce & t_read & empty_n_reg;

    assign i_rd = i_ce0 & ~i_we0;
    assign i_wr = i_ce0 & i_we0;
    assign t_rd = t_ce0 & ~t_we0;
    assign t_wr = t_ce0 & t_we0;

    assign i_addr_phys = {iptr_reg, i_address0};
    assign t_addr_phys = {tptr_reg, t_address0};

    // Explicit wrap so the ring length is BufferCount rather than 2**IndexWidth.
    assign iptr_next = (iptr_reg == LastIdx) ? '0 : iptr_reg + 1'b1;
    assign tptr_next = (tptr_reg == LastIdx) ? '0 : tptr_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (i_wr) begin
            mem[i_addr_phys] <= i_d0;
        end
        if (t_wr) begin
            mem[t_addr_phys] <= t_d0;
        end
    end

    // Read registers sample the array before this edge's writes land: read-old-data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_q_reg <= '0;
            t_q_reg <= '0;
        end else begin
            if (i_rd) begin
                i_q_reg <= mem[i_addr_phys];
            end
            if (t_rd) begin
                t_q_reg <= mem[t_addr_phys];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iptr_reg    <= '0;
            tptr_reg    <= '0;
            count_reg   <= '0;
            full_n_reg  <= 1'b1;
            empty_n_reg <= 1'b0;
        end else begin
            if (push) begin
                iptr_reg <= iptr_next;
            end
            if (pop) begin
                tptr_reg <= tptr_next;
            end
            if (push && !pop) begin
                count_reg   <= count_reg + 1'b1;
                empty_n_reg <= 1'b1;
                if (count_reg == AlmostFull) begin
                    full_n_reg <= 1'b0;
                end
            end else if (pop && !push) begin
                count_reg  <= count_reg - 1'b1;
                full_n_reg <= 1'b1;
                if (count_reg == OneBank) begin
                    empty_n_reg <= 1'b0;
                end
            end
        end
    end

    assign i_full_n  = full_n_reg;
    assign t_empty_n = empty_n_reg;
    assign count     = count_reg;
    assign i_q0      = i_q_reg;
    assign t_q0      = t_q_reg;

endmodule
